load_station_param: RTL and testbench
=====================================

# load_station_param

Parametrised load reservation station for the Tomasulo core. It sits between the issue stage and the load unit. It buffers up to DEPTH loads whose base register may still be pending, snoops the CDB for the missing base, and dispatches the oldest ready load with its effective address already computed. It adds five things not present in the first-generation station: synchronous reset, a flush, a valid/ready dispatch handshake, age-ordered selection and a bypass from issue to the CDB.

## Interface
Parameters:
- DEPTH, 4: number of entries (2..8).
- DATA_W, 32: data, immediate and address width.
- LABEL_W, 5: tag width. Label 0 means "value present".
- OP_W, 5: opcode width.
- LABEL_BASE, 1: tag of entry 0. Entry i has tag LABEL_BASE+i. Requires LABEL_BASE ≥ 1 and LABEL_BASE+DEPTH−1 < 2^LABEL_W.

Ports:
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: synchronous, active-low reset.
- flush, in, 1: synchronous clear of all entries.
- issue_en, in, 1: issue request.
- issue_op, in, OP_W: opcode.
- issue_base, in, DATA_W: base register value.
- issue_base_label, in, LABEL_W: producer tag of the base; 0 means the value is valid.
- issue_imm, in, DATA_W: offset.
- full, out, 1: no free entry.
- issue_label, out, LABEL_W: tag the issued load receives, i.e. the lowest-index free entry; 0 when full.
- bc_en, in, 1: CDB broadcast valid.
- bc_label, in, LABEL_W: CDB tag.
- bc_data, in, DATA_W: CDB value.
- out_valid, out, 1: a load is ready for dispatch.
- out_ready, in, 1: load unit accepts the load.
- out_op, out, OP_W: opcode of the dispatched load.
- out_addr, out, DATA_W: effective address, base+imm.
- out_label, out, LABEL_W: tag of the dispatched entry.
- count, out, $clog2(DEPTH+1): number of busy entries.

## Operation
- Per-entry state: busy, op, qj (tag), vj (value), imm, rank. rank is the number of older busy entries.
- Issue is accepted on a rising edge when rst_n && !flush && issue_en && !full. On acceptance:
  - The lowest-index free entry becomes busy.
  - The new entry's rank = count.
  - Bypass: if bc_en and bc_label == issue_base_label != 0, the entry captures qj=0 and vj=bc_data. Otherwise it captures the issue inputs.
- CDB snoop: on every edge with bc_en && bc_label != 0, each busy entry with qj == bc_label captures vj=bc_data and qj=0. bc_label == 0 is ignored.
- Ready entry: busy && qj == 0. out_valid = any ready entry && !flush. The selected entry is the ready entry with the lowest rank, which is strictly age-ordered.
- out_addr = vj + imm, truncated to DATA_W, combinational from the selected entry. The carry is discarded.
- Dispatch handshake: fires when out_valid && out_ready. On that edge the selected entry is freed, and every busy entry with a rank greater than the freed entry's rank decrements its rank.
- Issue and dispatch in the same cycle: both take effect. The new entry's rank = count−1, and count is unchanged.
- full and count are registered-state functions. A full station rejects issue even if a dispatch frees an entry in that same cycle.
- While out_valid is 0, out_op, out_addr and out_label drive 0.
- Flush: all busy, qj and rank values are cleared. A concurrent issue or dispatch is discarded.
- Reset (rst_n=0): same as flush. It also zeroes vj, imm and op.

## Timing
- Reset values: full=0, count=0, out_valid=0, out_op=0, out_addr=0, out_label=0, issue_label=LABEL_BASE.
- Issue to dispatch, base ready: out_valid rises in the cycle after the issue edge (1-cycle latency).
- Broadcast to dispatch: an entry woken on edge k can dispatch in cycle k+1.
- The dispatch outputs are combinational from state and flush. Registered state changes only on the rising edge of clk.
- Rank values always form a permutation of 0..count−1 across busy entries. A bench assertion checks this every cycle.

## Structure
- Shared package: label width, NO_LABEL=0 constant, opcode width.
- Sub-module rs_age_picker(DEPTH): inputs ready[DEPTH] and rank[DEPTH]; outputs a one-hot grant and an index. It is purely combinational.
- The station holds the entry array, allocate encoder, snoop/bypass, rank update and address adder.

## Test plan
- Reset, then issue base=0x100 label 0, imm=0x20 -> next cycle out_valid=1, out_addr=0x120, out_label=1, count=1.
- Issue A (label 7), then B (ready) -> B dispatches first. Broadcast tag 7 data 0x40 -> A dispatches the next cycle with addr 0x40+imm.
- Fill 4 entries with qj=9, out_ready=1 -> full=1, issue_label=0, a 5th issue is ignored. One broadcast of tag 9 -> all four dispatch in issue order over four cycles.
- Issue with issue_base_label=5 while bc_en, bc_label=5, bc_data=0xFFFFFFF0, imm=0x20 -> the entry is ready immediately, out_addr=0x10 (wrap).
- Hold out_ready=0 for 3 cycles -> out_valid stays 1 and outputs are stable. Simultaneous issue and dispatch -> count unchanged.
- Assert flush with 3 busy entries and issue_en=1 -> next cycle count=0, out_valid=0. rst_n low mid-operation behaves the same way.

Source files
------------

// File: rtl/load_station_param_pkg.sv
// load_station_param_pkg: shared tag/opcode widths and the "value present" tag
package load_station_param_pkg;
    localparam int LS_LABEL_W = 5;
    localparam int LS_OP_W = 5;
    localparam int NO_LABEL = 0;
endpackage

// File: rtl/rs_age_picker.sv
// rs_age_picker: grants the ready entry with the lowest rank (oldest), purely combinational
module rs_age_picker
    import load_station_param_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IW = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] ready,
    input  logic [IW-1:0]    rank [DEPTH],
    output logic [DEPTH-1:0] grant,
    output logic [IW-1:0]    idx
);
    logic          found;
    logic [IW-1:0] best;
    always_comb begin
        found = 1'b0;
        best = '0;
        idx = '0;
        for (int i = 0; i < DEPTH; i++)
            if (ready[i] && (!found || rank[i] < best)) begin
                found = 1'b1;
                best = rank[i];
                idx = IW'(i);
            end
        grant = found ? DEPTH'(1) << idx : '0;
    end
endmodule

// File: rtl/load_station_param.sv
// load_station_param: load reservation station with CDB snoop/bypass and age-ordered dispatch
module load_station_param
    import load_station_param_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DATA_W = 32,
    parameter int LABEL_W = LS_LABEL_W,
    parameter int OP_W = LS_OP_W,
    parameter int LABEL_BASE = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       issue_en,
    input  logic [OP_W-1:0]            issue_op,
    input  logic [DATA_W-1:0]          issue_base,
    input  logic [LABEL_W-1:0]         issue_base_label,
    input  logic [DATA_W-1:0]          issue_imm,
    output logic                       full,
    output logic [LABEL_W-1:0]         issue_label,
    input  logic                       bc_en,
    input  logic [LABEL_W-1:0]         bc_label,
    input  logic [DATA_W-1:0]          bc_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OP_W-1:0]            out_op,
    output logic [DATA_W-1:0]          out_addr,
    output logic [LABEL_W-1:0]         out_label,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [LABEL_W-1:0] NL = LABEL_W'(NO_LABEL);

    logic [DEPTH-1:0]   busy;
    logic [OP_W-1:0]    op   [DEPTH];
    logic [LABEL_W-1:0] qj   [DEPTH];
    logic [DATA_W-1:0]  vj   [DEPTH];
    logic [DATA_W-1:0]  imm  [DEPTH];
    logic [IW-1:0]      rank [DEPTH];

    logic [DEPTH-1:0] ready;
    logic [DEPTH-1:0] grant;
    logic [IW-1:0]    sel;
    logic [IW-1:0]    free_idx;
    logic [CW-1:0]    cnt;
    logic             fire;
    logic             accept;
    logic             snoop;
    logic             bypass;

    // Descending scan leaves the lowest-index free entry in free_idx
    always_comb begin
        free_idx = '0;
        cnt = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            free_idx = busy[i] ? free_idx : IW'(i);
            cnt = cnt + CW'(busy[i]);
        end
        for (int i = 0; i < DEPTH; i++)
            ready[i] = busy[i] && qj[i] == NL;
    end

    rs_age_picker #(.DEPTH(DEPTH), .IW(IW)) u_picker (
        .ready(ready),
        .rank(rank),
        .grant(grant),
        .idx(sel)
    );

    assign full = &busy;
    assign count = cnt;
    assign issue_label = full ? NL : LABEL_W'(LABEL_BASE + int'(free_idx));
    assign out_valid = |ready && !flush;
    assign out_op = out_valid ? op[sel] : '0;
    assign out_addr = out_valid ? vj[sel] + imm[sel] : '0;
    assign out_label = out_valid ? LABEL_W'(LABEL_BASE + int'(sel)) : NL;
    assign fire = out_valid && out_ready;
    assign accept = issue_en && !full && !flush;
    assign snoop = bc_en && bc_label != NL;
    assign bypass = snoop && bc_label == issue_base_label;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                op[i] <= '0;
                qj[i] <= NL;
                vj[i] <= '0;
                imm[i] <= '0;
                rank[i] <= '0;
            end
        end else if (flush) begin
            busy <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                qj[i] <= NL;
                rank[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (accept && IW'(i) == free_idx) begin
                    busy[i] <= 1'b1;
                    op[i] <= issue_op;
                    imm[i] <= issue_imm;
                    rank[i] <= fire ? IW'(cnt - CW'(1)) : IW'(cnt);
                    qj[i] <= bypass ? NL : issue_base_label;
                    vj[i] <= bypass ? bc_data : issue_base;
                end else if (fire && grant[i]) begin
                    busy[i] <= 1'b0;
                    rank[i] <= '0;
                end else if (busy[i]) begin
                    if (snoop && qj[i] == bc_label) begin
                        qj[i] <= NL;
                        vj[i] <= bc_data;
                    end
                    if (fire && rank[i] > rank[sel])
                        rank[i] <= rank[i] - IW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_load_station_param.sv
// tb_load_station_param: directed-vector checks of issue, snoop, bypass, age order, flush and reset
module tb_load_station_param;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        issue_en = 1'b0;
    logic [4:0]  issue_op = '0;
    logic [31:0] issue_base = '0;
    logic [4:0]  issue_base_label = '0;
    logic [31:0] issue_imm = '0;
    logic        full;
    logic [4:0]  issue_label;
    logic        bc_en = 1'b0;
    logic [4:0]  bc_label = '0;
    logic [31:0] bc_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  out_op;
    logic [31:0] out_addr;
    logic [4:0]  out_label;
    logic [2:0]  count;
    int tests = 0;
    int failed = 0;

    load_station_param dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .issue_en(issue_en), .issue_op(issue_op), .issue_base(issue_base),
        .issue_base_label(issue_base_label), .issue_imm(issue_imm),
        .full(full), .issue_label(issue_label),
        .bc_en(bc_en), .bc_label(bc_label), .bc_data(bc_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
        .out_addr(out_addr), .out_label(out_label), .count(count)
    );

    always #5 clk = ~clk;

    // Ranks of busy entries must be distinct and below count
    always @(negedge clk) begin
        if (rst_n) begin
            int seen;
            int r;
            bit ok;
            seen = 0;
            ok = 1'b1;
            for (int i = 0; i < 4; i++)
                if (dut.busy[i]) begin
                    r = int'(dut.rank[i]);
                    if (r >= int'(count) || seen[r]) ok = 1'b0;
                    seen[r] = 1'b1;
                end
            tests++;
            if (!ok) begin
                failed++;
                $display("FAIL rank_perm: ranks not a permutation of 0..%0d at %0t", count, $time);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] op, input logic [31:0] base, input logic [4:0] lbl, input logic [31:0] imm);
        issue_en = 1'b1;
        issue_op = op;
        issue_base = base;
        issue_base_label = lbl;
        issue_imm = imm;
        step();
        issue_en = 1'b0;
    endtask

    task automatic broadcast(input logic [4:0] lbl, input logic [31:0] data);
        bc_en = 1'b1;
        bc_label = lbl;
        bc_data = data;
        step();
        bc_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        tests++; if (full !== 1'b0) begin failed++; $display("FAIL reset_full: got %b want 0", full); end
        tests++; if (count !== 3'd0) begin failed++; $display("FAIL reset_count: got %0d want 0", count); end
        tests++; if ({out_valid, out_op, out_addr, out_label} !== '0) begin failed++; $display("FAIL reset_out: got v=%b op=%h a=%h l=%h want all 0", out_valid, out_op, out_addr, out_label); end
        tests++; if (issue_label !== 5'd1) begin failed++; $display("FAIL reset_issue_label: got %0d want 1", issue_label); end
    endtask

    task automatic test_basic();
        issue(5'd3, 32'h100, 5'd0, 32'h20);
        tests++; if (out_valid !== 1'b1) begin failed++; $display("FAIL basic_valid: got %b want 1", out_valid); end
        tests++; if (out_addr !== 32'h120) begin failed++; $display("FAIL basic_addr: got %h want 120", out_addr); end
        tests++; if (out_label !== 5'd1 || out_op !== 5'd3) begin failed++; $display("FAIL basic_label_op: got l=%0d op=%0d want l=1 op=3", out_label, out_op); end
        tests++; if (count !== 3'd1) begin failed++; $display("FAIL basic_count: got %0d want 1", count); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        tests++; if (count !== 3'd0 || out_valid !== 1'b0) begin failed++; $display("FAIL basic_drain: got c=%0d v=%b want c=0 v=0", count, out_valid); end
    endtask

    task automatic test_wakeup_order();
        issue(5'd1, 32'h0, 5'd7, 32'h8);
        issue(5'd2, 32'h200, 5'd0, 32'h4);
        tests++; if (out_label !== 5'd2 || out_addr !== 32'h204) begin failed++; $display("FAIL order_b_first: got l=%0d a=%h want l=2 a=204", out_label, out_addr); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        tests++; if (out_valid !== 1'b0 || count !== 3'd1) begin failed++; $display("FAIL order_a_waits: got v=%b c=%0d want v=0 c=1", out_valid, count); end
        broadcast(5'd7, 32'h40);
        tests++; if (out_valid !== 1'b1 || out_label !== 5'd1 || out_addr !== 32'h48) begin failed++; $display("FAIL order_a_wake: got v=%b l=%0d a=%h want v=1 l=1 a=48", out_valid, out_label, out_addr); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        tests++; if (count !== 3'd0) begin failed++; $display("FAIL order_drain: got %0d want 0", count); end
    endtask

    task automatic test_full();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tests++; if (issue_label !== 5'(k + 1)) begin failed++; $display("FAIL full_issue_label%0d: got %0d want %0d", k, issue_label, k + 1); end
            issue(5'(k + 4), 32'h0, 5'd9, 32'(k * 16));
        end
        tests++; if (full !== 1'b1 || issue_label !== 5'd0 || count !== 3'd4) begin failed++; $display("FAIL full_state: got f=%b il=%0d c=%0d want f=1 il=0 c=4", full, issue_label, count); end
        tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL full_none_ready: got %b want 0", out_valid); end
        issue(5'd31, 32'h0, 5'd0, 32'h999);
        tests++; if (count !== 3'd4 || out_valid !== 1'b0) begin failed++; $display("FAIL full_reject: got c=%0d v=%b want c=4 v=0", count, out_valid); end
        broadcast(5'd9, 32'h1000);
        for (int k = 0; k < 4; k++) begin
            tests++; if (out_valid !== 1'b1 || out_label !== 5'(k + 1) || out_addr !== 32'(32'h1000 + k * 16) || out_op !== 5'(k + 4)) begin failed++; $display("FAIL full_drain%0d: got v=%b l=%0d a=%h op=%0d want v=1 l=%0d a=%h op=%0d", k, out_valid, out_label, out_addr, out_op, k + 1, 32'h1000 + k * 16, k + 4); end
            step();
        end
        out_ready = 1'b0;
        tests++; if (count !== 3'd0 || full !== 1'b0) begin failed++; $display("FAIL full_empty: got c=%0d f=%b want c=0 f=0", count, full); end
    endtask

    task automatic test_bypass_hold();
        bc_en = 1'b1;
        bc_label = 5'd5;
        bc_data = 32'hFFFF_FFF0;
        issue(5'd2, 32'hDEAD, 5'd5, 32'h20);
        bc_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tests++; if (out_valid !== 1'b1 || out_addr !== 32'h10 || out_label !== 5'd1 || out_op !== 5'd2) begin failed++; $display("FAIL bypass_hold%0d: got v=%b a=%h l=%0d op=%0d want v=1 a=10 l=1 op=2", k, out_valid, out_addr, out_label, out_op); end
            step();
        end
        out_ready = 1'b1;
        issue(5'd6, 32'h300, 5'd0, 32'h0);
        out_ready = 1'b0;
        tests++; if (count !== 3'd1 || out_label !== 5'd2 || out_addr !== 32'h300) begin failed++; $display("FAIL issue_and_dispatch: got c=%0d l=%0d a=%h want c=1 l=2 a=300", count, out_label, out_addr); end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_age_not_index();
        issue(5'd1, 32'h10, 5'd0, 32'h0);
        issue(5'd2, 32'h0, 5'd6, 32'h4);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        issue(5'd3, 32'h30, 5'd0, 32'h0);
        tests++; if (out_label !== 5'd1 || out_addr !== 32'h30) begin failed++; $display("FAIL age_young_only: got l=%0d a=%h want l=1 a=30", out_label, out_addr); end
        broadcast(5'd6, 32'h50);
        tests++; if (out_label !== 5'd2 || out_addr !== 32'h54) begin failed++; $display("FAIL age_older_first: got l=%0d a=%h want l=2 a=54", out_label, out_addr); end
        out_ready = 1'b1;
        step();
        tests++; if (out_label !== 5'd1 || out_addr !== 32'h30) begin failed++; $display("FAIL age_younger_next: got l=%0d a=%h want l=1 a=30", out_label, out_addr); end
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_flush_reset();
        for (int k = 0; k < 3; k++) issue(5'd1, 32'(k), 5'd0, 32'h0);
        tests++; if (count !== 3'd3) begin failed++; $display("FAIL flush_pre: got %0d want 3", count); end
        flush = 1'b1;
        issue_en = 1'b1;
        out_ready = 1'b1;
        #1;
        tests++; if (out_valid !== 1'b0 || out_addr !== 32'h0) begin failed++; $display("FAIL flush_comb: got v=%b a=%h want 0 0", out_valid, out_addr); end
        step();
        flush = 1'b0;
        issue_en = 1'b0;
        out_ready = 1'b0;
        tests++; if (count !== 3'd0 || out_valid !== 1'b0 || issue_label !== 5'd1) begin failed++; $display("FAIL flush_post: got c=%0d v=%b il=%0d want 0 0 1", count, out_valid, issue_label); end
        issue(5'd1, 32'h1, 5'd0, 32'h0);
        issue(5'd1, 32'h2, 5'd3, 32'h0);
        rst_n = 1'b0;
        issue_en = 1'b1;
        step();
        rst_n = 1'b1;
        issue_en = 1'b0;
        tests++; if (count !== 3'd0 || out_valid !== 1'b0 || issue_label !== 5'd1 || full !== 1'b0) begin failed++; $display("FAIL reset_mid: got c=%0d v=%b il=%0d f=%b want 0 0 1 0", count, out_valid, issue_label, full); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wakeup_order();
        test_full();
        test_bypass_hold();
        test_age_not_index();
        test_flush_reset();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
